// File: rtl/reg_file.sv
// Register file with two combinational read ports and one write port.
// x0 is hardwired to zero. An optional same-cycle write-to-read bypass is provided.
// write_count is a wrapping 16-bit tally of committed writes.
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [15:0]       write_count
);

    localparam logic BYP_EN = (BYPASS != 0);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_commit;
    logic              rd_in_range;
    logic              rs1_in_range;
    logic              rs2_in_range;

    // Index range checks; they only matter when NUM_REGS is not a power of two
    always_comb begin
        rd_in_range  = ({1'b0, rd_addr}  < (ADDR_W+1)'(NUM_REGS));
        rs1_in_range = ({1'b0, rs1_addr} < (ADDR_W+1)'(NUM_REGS));
        rs2_in_range = ({1'b0, rs2_addr} < (ADDR_W+1)'(NUM_REGS));
    end

    // A write commits only outside reset, to a real non-zero register
    always_comb begin
        wr_commit = reset_n && reg_write && (rd_addr != '0) && rd_in_range;
    end

    // Storage update and commit counter; reset clears everything and drops a coincident write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
            write_count <= '0;
        end else if (wr_commit) begin
            regs[rd_addr] <= rd_data;
            write_count   <= write_count + 16'd1;
        end
    end

    // Read port 1: zero for x0 and out-of-range indices; bypass rides on wr_commit so it is off during reset
    always_comb begin
        rs1_data = '0;
        if ((rs1_addr != '0) && rs1_in_range) begin
            if (BYP_EN && wr_commit && (rs1_addr == rd_addr)) begin
                rs1_data = rd_data;
            end else begin
                rs1_data = regs[rs1_addr];
            end
        end
    end

    // Read port 2: same behaviour as port 1, fully independent
    always_comb begin
        rs2_data = '0;
        if ((rs2_addr != '0) && rs2_in_range) begin
            if (BYP_EN && wr_commit && (rs2_addr == rd_addr)) begin
                rs2_data = rd_data;
            end else begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand-written corner sequences,
// randomized traffic against an array-based reference model, and counter wrap.
// Three instances share inputs: default, BYPASS=0, and NUM_REGS=24.
module tb_reg_file;

    logic        clk;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;

    logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2, c_rs1, c_rs2;
    logic [15:0] a_cnt, b_cnt, c_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] mem [32];
    logic [15:0] cnt32;
    logic [15:0] cnt24;

    typedef struct {
        logic        rstn;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e1nb;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [11];

    reg_file u_dut (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .rd_addr(rd_addr),
        .rd_data(rd_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(a_rs1), .rs2_data(a_rs2), .write_count(a_cnt)
    );

    reg_file #(.BYPASS(0)) u_nb (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .rd_addr(rd_addr),
        .rd_data(rd_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1), .rs2_data(b_rs2), .write_count(b_cnt)
    );

    reg_file #(.NUM_REGS(24)) u_n24 (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .rd_addr(rd_addr),
        .rd_data(rd_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(c_rs1), .rs2_data(c_rs2), .write_count(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reg_write must never be X/Z outside reset
    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            assert (!$isunknown(reg_write)) else begin
                errors++;
                $display("FAIL reg_write_known: got %b expected 0 or 1", reg_write);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // expected read value from the architectural rules
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input int n, input bit byp);
        if (a == 5'd0 || int'(a) >= n) return 32'h0;
        if (byp && reset_n && reg_write && rd_addr == a) return rd_data;
        return mem[a];
    endfunction

    task automatic apply(input logic rstn, input logic we, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        reset_n   = rstn;
        reg_write = we;
        rd_addr   = rd;
        rd_data   = wd;
        rs1_addr  = a1;
        rs2_addr  = a2;
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            cnt32 = 16'h0;
            cnt24 = 16'h0;
        end else if (reg_write && rd_addr != 5'd0) begin
            mem[rd_addr] = rd_data;
            cnt32 = cnt32 + 16'd1;
            if (rd_addr < 5'd24) begin
                mem[rd_addr] = rd_data;
                cnt24 = cnt24 + 16'd1;
            end
        end
    endtask

    task automatic check_all();
        chk("byp_rs1", a_rs1, exp_rd(rs1_addr, 32, 1'b1));
        chk("byp_rs2", a_rs2, exp_rd(rs2_addr, 32, 1'b1));
        chk("byp_cnt", {16'h0, a_cnt}, {16'h0, cnt32});
        chk("nob_rs1", b_rs1, exp_rd(rs1_addr, 32, 1'b0));
        chk("nob_rs2", b_rs2, exp_rd(rs2_addr, 32, 1'b0));
        chk("nob_cnt", {16'h0, b_cnt}, {16'h0, cnt32});
        chk("n24_rs1", c_rs1, exp_rd(rs1_addr, 24, 1'b1));
        chk("n24_rs2", c_rs2, exp_rd(rs2_addr, 24, 1'b1));
        chk("n24_cnt", {16'h0, c_cnt}, {16'h0, cnt24});
    endtask

    initial begin
        reset_n = 1'b0; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        cnt32 = 16'h0;
        cnt24 = 16'h0;

        //            rstn  we    rd     wd            a1     a2     e1            e2            e1nb          ecnt
        tbl[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 5'd0,  32'h00000000, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        tbl[2]  = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF, 32'h00000000, 16'd1};
        tbl[3]  = '{1'b1, 1'b0, 5'd0,  32'h00000000, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 16'd1};
        tbl[4]  = '{1'b1, 1'b1, 5'd7,  32'h11111111, 5'd7,  5'd3,  32'h11111111, 32'h00000000, 32'h00000000, 16'd1};
        tbl[5]  = '{1'b1, 1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h22222222, 32'h22222222, 32'h11111111, 16'd2};
        tbl[6]  = '{1'b1, 1'b0, 5'd0,  32'h00000000, 5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF, 32'h22222222, 16'd3};
        tbl[7]  = '{1'b0, 1'b1, 5'd10, 32'h12345678, 5'd10, 5'd5,  32'h00000000, 32'hDEADBEEF, 32'h00000000, 16'd3};
        tbl[8]  = '{1'b1, 1'b0, 5'd0,  32'h00000000, 5'd10, 5'd5,  32'h00000000, 32'h00000000, 32'h00000000, 16'd0};
        tbl[9]  = '{1'b1, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0,  32'hA5A5A5A5, 32'h00000000, 32'h00000000, 16'd0};
        tbl[10] = '{1'b1, 1'b0, 5'd0,  32'h00000000, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'd1};

        // reset with a write pending; it must be dropped
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd0);
            commit();
        end

        // post-reset sweep of every index on both ports
        for (int i = 0; i < 32; i++) begin
            apply(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            chk("rst_rs1", a_rs1, 32'h0);
            chk("rst_rs2", a_rs2, 32'h0);
            chk("rst_cnt", {16'h0, a_cnt}, 32'h0);
            commit();
        end

        // directed vector table
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].rstn, tbl[i].we, tbl[i].rd, tbl[i].wd, tbl[i].a1, tbl[i].a2);
            check_all();
            chk("tbl_rs1", a_rs1, tbl[i].e1);
            chk("tbl_rs2", a_rs2, tbl[i].e2);
            chk("tbl_nb_rs1", b_rs1, tbl[i].e1nb);
            chk("tbl_cnt", {16'h0, a_cnt}, {16'h0, tbl[i].ecnt});
            commit();
        end

        // out-of-range index on the 24-entry instance: write ignored, reads zero
        apply(1'b1, 1'b1, 5'd26, 32'h0BADCAFE, 5'd26, 5'd26);
        chk("n24_oor_byp", c_rs1, 32'h0);
        commit();
        apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd26, 5'd23);
        chk("n24_oor_rd", c_rs1, 32'h0);
        chk("full_x26", a_rs1, 32'h0BADCAFE);
        check_all();
        commit();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic       rn, we;
            logic [4:0] rd, a1, a2;
            rn = ($urandom_range(0, 49) != 0);
            we = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            apply(rn, we, rd, $urandom, a1, a2);
            check_all();
            commit();
        end

        // write_count wrap: 65537 writes to x1 from reset
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        commit();
        for (int i = 0; i < 65537; i++) begin
            apply(1'b1, 1'b1, 5'd1, 32'(i), 5'd1, 5'd0);
            commit();
        end
        apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
        chk("wrap_cnt", {16'h0, a_cnt}, 32'h1);
        chk("wrap_nb_cnt", {16'h0, b_cnt}, 32'h1);
        chk("wrap_x1", a_rs1, 32'd65536);
        chk("wrap_x1_p2", a_rs2, 32'd65536);
        check_all();
        commit();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL declare parameter DATA_W, default 32, register and data-port width in bits.
REQ-002 The block SHALL declare parameter NUM_REGS, default 32, number of architectural registers; ADDR_W = clog2(NUM_REGS).
REQ-003 The block SHALL declare parameter BYPASS, default 1; 1 forwards the same-cycle write to the read ports, 0 does not.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock, sole clock of the block.
REQ-005 The block SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 The block SHALL have port reg_write  input  1  write enable for the write port.
REQ-007 The block SHALL have port rd_addr  input  ADDR_W  write-port register index.
REQ-008 The block SHALL have port rd_data  input  DATA_W  write-port data.
REQ-009 The block SHALL have port rs1_addr  input  ADDR_W  read-port-1 register index.
REQ-010 The block SHALL have port rs2_addr  input  ADDR_W  read-port-2 register index.
REQ-011 The block SHALL have port rs1_data  output  DATA_W  read-port-1 data, feeding ALU operand A.
REQ-012 The block SHALL have port rs2_data  output  DATA_W  read-port-2 data, feeding the Data1 input of the ALU-B operand 2:1 mux.
REQ-013 The block SHALL have port write_count  output  16  count of committed writes since reset, for bench observation.

Function
REQ-014 Storage SHALL be NUM_REGS registers of DATA_W bits; register 0 SHALL be hardwired to zero.
REQ-015 Writes SHALL commit on the rising clk edge when reset_n=1, reg_write=1 and rd_addr!=0; rd_data is stored to reg[rd_addr].
REQ-016 A write with rd_addr=0 SHALL be discarded; reg[0] SHALL read 0 in every cycle.
REQ-017 Reads SHALL be combinational: rsN_data = reg[rsN_addr] with zero clock latency.
REQ-018 With BYPASS=1 and reg_write=1, rd_addr!=0, rsN_addr==rd_addr, rsN_data SHALL equal rd_data in the same cycle.
REQ-019 With BYPASS=0, that same case SHALL return the old register value; the new value becomes visible the cycle after the edge.
REQ-020 rsN_addr=0 SHALL return 0 regardless of any write or bypass condition.
REQ-021 Both read ports SHALL be independent; rs1_addr==rs2_addr SHALL return identical data on both ports.
REQ-022 Addresses >= NUM_REGS, when NUM_REGS is not a power of two, SHALL read 0 and SHALL NOT be written.
REQ-023 write_count SHALL increment by 1 on each committed write (REQ-015 conditions only) and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 X or Z on reg_write SHALL NOT be tolerated; the bench SHALL assert that reg_write is known whenever reset_n=1.

Reset
REQ-025 When reset_n=0 at a rising edge, all registers SHALL clear to 0 and write_count SHALL clear to 0.
REQ-026 A write presented in the same cycle as reset (reset_n=0, reg_write=1) SHALL be dropped; reset has priority.
REQ-027 During reset, read ports SHALL still be combinational, returning stored values; the bypass of REQ-018 SHALL be disabled while reset_n=0.
REQ-028 The first write SHALL be accepted on the first rising edge with reset_n=1.

Verification
REQ-029 Reset, then read all indices 0..31 on both ports -> every rs1_data and rs2_data = 0x00000000, write_count=0.
REQ-030 Write 0xDEADBEEF to x5, then read rs1_addr=5 and rs2_addr=5 the next cycle -> both read 0xDEADBEEF, write_count=1.
REQ-031 Write 0xFFFFFFFF with rd_addr=0, then read x0 -> 0x00000000, write_count unchanged.
REQ-032 BYPASS=1: x7=0x11111111, then in one cycle write 0x22222222 to x7 with rs1_addr=7 -> rs1_data=0x22222222 before the edge; BYPASS=0 -> 0x11111111 before the edge and 0x22222222 after.
REQ-033 Write 0x12345678 to x10 with reset_n=0 in the same cycle -> x10 reads 0 afterwards, write_count=0.
REQ-034 Issue 65537 writes to x1 -> write_count=0x0001 (wrap), x1 holds the last written value.
